// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and helpers for the level countdown timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Wide enough for the largest supported display (four digits, 9999).
    localparam int COUNT_W = 14;

    function automatic int max_count(input int num_digits);
        int m;
        m = 1;
        for (int i = 0; i < num_digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

    function automatic bcd_digit_t bin_to_bcd(input logic [31:0] value, input int digit);
        logic [31:0] v;
        v = value;
        for (int i = 0; i < 4; i++) begin
            if (i < digit) begin
                v = v / 32'd10;
            end
        end
        return bcd_digit_t'(v % 32'd10);
    endfunction

endpackage

// File: rtl/level_countdown_timer_if.sv
// rtl/level_countdown_timer_if.sv - control and display signals between level controller and timer
interface level_countdown_timer_if #(
    parameter int NUM_DIGITS  = 2,
    parameter int BONUS_WIDTH = 7
);
    logic                    start_level;
    logic                    pause;
    logic                    one_sec_tick;
    logic                    add_time;
    logic [BONUS_WIDTH-1:0]  bonus_amount;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    enable_timer;
    logic                    timer_ended;
    logic                    expired;
    logic                    low_time;

    modport master (
        output start_level, pause, one_sec_tick, add_time, bonus_amount,
        input  digits, enable_timer, timer_ended, expired, low_time
    );

    modport slave (
        input  start_level, pause, one_sec_tick, add_time, bonus_amount,
        output digits, enable_timer, timer_ended, expired, low_time
    );
endinterface

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - binary count with load, decrement, saturating add and registered BCD view
module bcd_down_counter
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int BONUS_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    load,
    input  logic [COUNT_W-1:0]      load_value,
    input  logic                    dec,
    input  logic                    add,
    input  logic [BONUS_WIDTH-1:0]  add_value,
    output logic [COUNT_W-1:0]      count,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    next_zero
);

    localparam logic [31:0] MAX = 32'(max_count(NUM_DIGITS));

    logic [31:0]             sum_sat;
    logic [COUNT_W-1:0]      count_next;
    logic [4*NUM_DIGITS-1:0] digits_next;

    // Saturate after the add, then take the tick, so a bonus can rescue a count of 1.
    always_comb begin
        sum_sat = 32'(count) + (add ? 32'(add_value) : 32'd0);
        if (sum_sat > MAX) begin
            sum_sat = MAX;
        end
        if (dec && (sum_sat != 32'd0)) begin
            sum_sat = sum_sat - 32'd1;
        end
        count_next  = load ? load_value : COUNT_W'(sum_sat);
        digits_next = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digits_next[4*d +: 4] = bin_to_bcd(32'(count_next), d);
        end
    end

    assign next_zero = (count_next == '0);

    // BCD is converted from the next value so digits and count always land on the same edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count  <= '0;
            digits <= '0;
        end else begin
            count  <= count_next;
            digits <= digits_next;
        end
    end

endmodule

// File: rtl/level_countdown_timer.sv
// rtl/level_countdown_timer.sv - level countdown FSM with pause, bonus time and low-time warning
module level_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int START_VALUE    = 60,
    parameter int WARN_THRESHOLD = 10,
    parameter int BONUS_WIDTH    = 7
) (
    input logic                    clk,
    input logic                    resetN,
    level_countdown_timer_if.slave bus
);

    localparam logic [COUNT_W-1:0] START_C = COUNT_W'(START_VALUE);
    localparam logic [COUNT_W-1:0] WARN_C  = COUNT_W'(WARN_THRESHOLD);

    timer_state_t            state;
    logic                    enable_r;
    logic                    ended_r;
    logic                    expired_r;
    logic [COUNT_W-1:0]      count;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    next_zero;
    logic                    dec;
    logic                    add;

    // A high pause blocks the tick even in the cycle RUNNING hands over to PAUSED.
    assign dec = (state == RUNNING) && bus.one_sec_tick && !bus.pause && !bus.start_level;
    assign add = bus.add_time && ((state == RUNNING) || (state == PAUSED));

    bcd_down_counter #(
        .NUM_DIGITS  (NUM_DIGITS),
        .BONUS_WIDTH (BONUS_WIDTH)
    ) u_counter (
        .clk        (clk),
        .resetN     (resetN),
        .load       (bus.start_level),
        .load_value (START_C),
        .dec        (dec),
        .add        (add),
        .add_value  (bus.bonus_amount),
        .count      (count),
        .digits     (digits),
        .next_zero  (next_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            enable_r  <= 1'b0;
            ended_r   <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            ended_r <= 1'b0;
            if (bus.start_level) begin
                if (START_VALUE == 0) begin
                    state     <= EXPIRED;
                    enable_r  <= 1'b0;
                    ended_r   <= 1'b1;
                    expired_r <= 1'b1;
                end else begin
                    state     <= RUNNING;
                    enable_r  <= 1'b1;
                    expired_r <= 1'b0;
                end
            end else begin
                case (state)
                    RUNNING: begin
                        if (dec && next_zero) begin
                            state     <= EXPIRED;
                            enable_r  <= 1'b0;
                            ended_r   <= 1'b1;
                            expired_r <= 1'b1;
                        end else if (bus.pause) begin
                            state    <= PAUSED;
                            enable_r <= 1'b0;
                        end
                    end
                    PAUSED: begin
                        if (!bus.pause) begin
                            state    <= RUNNING;
                            enable_r <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.digits       = digits;
    assign bus.enable_timer = enable_r;
    assign bus.timer_ended  = ended_r;
    assign bus.expired      = expired_r;
    assign bus.low_time     = ((state == RUNNING) || (state == PAUSED))
                              && (count != '0) && (count <= WARN_C);

endmodule

// File: tb/tb_level_countdown_timer.sv
// tb/tb_level_countdown_timer.sv - randomized bench for level_countdown_timer against a behavioural model
module tb_level_countdown_timer;

    localparam int ND   = 2;
    localparam int SV   = 60;
    localparam int WT   = 10;
    localparam int BW   = 7;
    localparam int MAXC = 99;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    level_countdown_timer_if #(.NUM_DIGITS(ND), .BONUS_WIDTH(BW)) bus ();
    level_countdown_timer_if #(.NUM_DIGITS(3),  .BONUS_WIDTH(BW)) bus3 ();

    level_countdown_timer #(
        .NUM_DIGITS(ND), .START_VALUE(SV), .WARN_THRESHOLD(WT), .BONUS_WIDTH(BW)
    ) dut (.clk(clk), .resetN(resetN), .bus(bus));

    level_countdown_timer #(
        .NUM_DIGITS(3), .START_VALUE(100), .WARN_THRESHOLD(WT), .BONUS_WIDTH(BW)
    ) dut3 (.clk(clk), .resetN(resetN), .bus(bus3));

    int n_pass  = 0;
    int n_total = 0;

    // Model: mode 0 idle, 1 running, 2 paused, 3 expired.
    int m_mode  = 0;
    int m_count = 0;
    int m_ended = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int to_bcd(input int c);
        return ((c / 10) % 10) * 16 + (c % 10);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_count = 0;
        m_ended = 0;
    endtask

    task automatic model_edge(input int st, input int pa, input int tk, input int ad, input int b);
        int c;
        m_ended = 0;
        if (st != 0) begin
            m_count = SV;
            m_mode  = 1;
        end else if (m_mode == 1) begin
            c = m_count;
            if (ad != 0) c = (c + b > MAXC) ? MAXC : c + b;
            if (tk != 0 && pa == 0) begin
                c = c - 1;
                if (c == 0) begin
                    m_mode  = 3;
                    m_ended = 1;
                end
            end
            m_count = c;
            if (m_mode == 1 && pa != 0) m_mode = 2;
        end else if (m_mode == 2) begin
            if (ad != 0) m_count = (m_count + b > MAXC) ? MAXC : m_count + b;
            if (pa == 0) m_mode = 1;
        end
    endtask

    task automatic compare_model();
        int active;
        active = (m_mode == 1 || m_mode == 2) ? 1 : 0;
        check("digits",       int'(bus.digits),  to_bcd(m_count));
        check("enable_timer", int'(bus.enable_timer), (m_mode == 1) ? 1 : 0);
        check("timer_ended",  int'(bus.timer_ended),  m_ended);
        check("expired",      int'(bus.expired),      (m_mode == 3) ? 1 : 0);
        check("low_time",     int'(bus.low_time),
              (active != 0 && m_count >= 1 && m_count <= WT) ? 1 : 0);
    endtask

    task automatic step();
        int st, pa, tk, ad, b;
        st = int'(bus.start_level);
        pa = int'(bus.pause);
        tk = int'(bus.one_sec_tick);
        ad = int'(bus.add_time);
        b  = int'(bus.bonus_amount);
        @(posedge clk);
        model_edge(st, pa, tk, ad, b);
        #1;
        compare_model();
    endtask

    task automatic tick_once();
        bus.one_sec_tick = 1'b1;
        step();
        bus.one_sec_tick = 1'b0;
    endtask

    task automatic start_once();
        bus.start_level = 1'b1;
        step();
        bus.start_level = 1'b0;
    endtask

    initial begin
        bus.start_level   = 1'b0;
        bus.pause         = 1'b0;
        bus.one_sec_tick  = 1'b0;
        bus.add_time      = 1'b0;
        bus.bonus_amount  = '0;
        bus3.start_level  = 1'b0;
        bus3.pause        = 1'b0;
        bus3.one_sec_tick = 1'b0;
        bus3.add_time     = 1'b0;
        bus3.bonus_amount = '0;
        #2;
        check("reset_digits",  int'(bus.digits), 0);
        check("reset_enable",  int'(bus.enable_timer), 0);
        check("reset_expired", int'(bus.expired), 0);
        model_reset();
        #1 resetN = 1'b1;

        start_once();
        check("start_digits", int'(bus.digits), 'h60);
        check("start_enable", int'(bus.enable_timer), 1);

        for (int k = 1; k <= SV; k++) begin
            tick_once();
            if (k == 49) check("low_at_11", int'(bus.low_time), 0);
            if (k == 50) check("low_at_10", int'(bus.low_time), 1);
            if (k == 51) check("ten_to_09", int'(bus.digits), 'h09);
            if (k == SV) begin
                check("end_digits",  int'(bus.digits), 'h00);
                check("end_pulse",   int'(bus.timer_ended), 1);
                check("end_expired", int'(bus.expired), 1);
                check("end_enable",  int'(bus.enable_timer), 0);
                check("end_low",     int'(bus.low_time), 0);
            end
            step();
        end
        check("pulse_one_cycle", int'(bus.timer_ended), 0);
        for (int k = 0; k < 3; k++) tick_once();
        check("expired_hold", int'(bus.digits), 'h00);

        start_once();
        check("restart_digits",  int'(bus.digits), 'h60);
        check("restart_expired", int'(bus.expired), 0);
        for (int k = 0; k < 30; k++) tick_once();
        bus.pause = 1'b1;
        for (int k = 0; k < 5; k++) tick_once();
        check("pause_digits", int'(bus.digits), 'h30);
        check("pause_enable", int'(bus.enable_timer), 0);
        bus.pause = 1'b0;
        step();
        tick_once();
        check("resume_tick", int'(bus.digits), 'h29);

        bus.add_time     = 1'b1;
        bus.bonus_amount = 7'd66;
        step();
        check("bonus_95", int'(bus.digits), 'h95);
        bus.bonus_amount = 7'd10;
        step();
        check("bonus_sat", int'(bus.digits), 'h99);
        bus.add_time = 1'b0;

        start_once();
        for (int k = 0; k < SV - 1; k++) tick_once();
        check("at_one", int'(bus.digits), 'h01);
        bus.add_time     = 1'b1;
        bus.bonus_amount = 7'd5;
        tick_once();
        bus.add_time = 1'b0;
        check("rescue_digits", int'(bus.digits), 'h05);
        check("rescue_pulse",  int'(bus.timer_ended), 0);

        bus3.start_level = 1'b1;
        step();
        bus3.start_level = 1'b0;
        check("nd3_load", int'(bus3.digits), 'h100);
        bus3.one_sec_tick = 1'b1;
        step();
        bus3.one_sec_tick = 1'b0;
        check("nd3_borrow", int'(bus3.digits), 'h099);

        start_once();
        for (int k = 0; k < 3; k++) tick_once();
        resetN = 1'b0;
        #1;
        check("async_digits",  int'(bus.digits), 0);
        check("async_enable",  int'(bus.enable_timer), 0);
        check("async_low",     int'(bus.low_time), 0);
        check("async_expired", int'(bus.expired), 0);
        model_reset();
        #1 resetN = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                resetN = 1'b0;
                #1;
                model_reset();
                compare_model();
                #1 resetN = 1'b1;
            end
            if (m_mode == 0 || m_mode == 3)
                bus.start_level = ($urandom_range(0, 29) == 0);
            else
                bus.start_level = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            bus.one_sec_tick = ($urandom_range(0, 2) == 0);
            bus.add_time     = ($urandom_range(0, 29) == 0);
            bus.bonus_amount = 7'($urandom_range(0, 127));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
